// File: rtl/maxnet_winner_select.sv
// Result stage for the four-unit MaxNet: captures PU outputs on a rising done
// edge, scans them one per cycle, and holds the winner behind valid/ready.
// Optional handshake counter on port run_count when MAXNET_STATS_EN is defined.
module maxnet_winner_select #(
  parameter int W    = 5,
  parameter int FRAC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         done,
  input  logic [W-1:0] pu_out1,
  input  logic [W-1:0] pu_out2,
  input  logic [W-1:0] pu_out3,
  input  logic [W-1:0] pu_out4,
  input  logic         win_ready,
  output logic         win_valid,
  output logic [1:0]   win_idx,
  output logic [3:0]   win_onehot,
  output logic [W-1:0] win_value,
  output logic         no_winner,
  output logic         multi_winner,
  output logic         overrun
`ifdef MAXNET_STATS_EN
  ,
  output logic [15:0]  run_count
`endif
);

  if (FRAC < 0 || FRAC >= W) begin : g_frac_check
    $error("FRAC must lie in [0, W-1]");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_RESULT = 2'd2
  } state_e;

  function automatic logic [3:0] idx_decode(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    case (idx)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  state_e               state_q, state_d;
  logic                 done_d_q;
  logic signed [W-1:0]  v_q [4];
  logic signed [W-1:0]  v_d [4];
  logic [1:0]           best_idx_q, best_idx_d;
  logic signed [W-1:0]  best_val_q, best_val_d;
  logic [2:0]           pos_cnt_q, pos_cnt_d;
  logic [1:0]           k_q, k_d;

  logic                 win_valid_q, win_valid_d;
  logic [1:0]           win_idx_q, win_idx_d;
  logic [3:0]           win_onehot_q, win_onehot_d;
  logic [W-1:0]         win_value_q, win_value_d;
  logic                 no_winner_q, no_winner_d;
  logic                 multi_winner_q, multi_winner_d;
  logic                 overrun_q, overrun_d;
  logic [15:0]          run_count_q, run_count_d;

  logic                 start_s;
  logic                 handshake_s;
  logic signed [W-1:0]  v_k_s;
  logic                 pos_k_s;
  logic                 better_s;
  logic [2:0]           pos_cnt_nx_s;
  logic [1:0]           best_idx_nx_s;
  logic signed [W-1:0]  best_val_nx_s;

  assign start_s     = done & ~done_d_q;
  assign handshake_s = win_valid_q & win_ready;

  // Per-cycle scan step: positivity count and running maximum (lower index wins ties)
  always_comb begin
    v_k_s         = v_q[k_q];
    pos_k_s       = ~v_k_s[W-1] & (v_k_s != {W{1'b0}});
    better_s      = (k_q != 2'd0) && (v_k_s > best_val_q);
    pos_cnt_nx_s  = pos_cnt_q;
    best_idx_nx_s = best_idx_q;
    best_val_nx_s = best_val_q;
    if (pos_k_s && (pos_cnt_q != 3'd4)) begin
      pos_cnt_nx_s = pos_cnt_q + 3'd1;
    end else begin
      pos_cnt_nx_s = pos_cnt_q;
    end
    if (better_s) begin
      best_idx_nx_s = k_q;
      best_val_nx_s = v_k_s;
    end else begin
      best_idx_nx_s = best_idx_q;
      best_val_nx_s = best_val_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) state_d = S_SCAN;
        else         state_d = S_IDLE;
      end
      S_SCAN: begin
        if (k_q == 2'd3) state_d = S_RESULT;
        else             state_d = S_SCAN;
      end
      S_RESULT: begin
        if (handshake_s) state_d = S_IDLE;
        else             state_d = S_RESULT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture and scan datapath updates
  always_comb begin
    v_d        = v_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    pos_cnt_d  = pos_cnt_q;
    k_d        = k_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          v_d[0]     = pu_out1;
          v_d[1]     = pu_out2;
          v_d[2]     = pu_out3;
          v_d[3]     = pu_out4;
          best_idx_d = 2'd0;
          best_val_d = pu_out1;
          pos_cnt_d  = 3'd0;
          k_d        = 2'd0;
        end else begin
          k_d = k_q;
        end
      end
      S_SCAN: begin
        pos_cnt_d  = pos_cnt_nx_s;
        best_idx_d = best_idx_nx_s;
        best_val_d = best_val_nx_s;
        k_d        = k_q + 2'd1;
      end
      S_RESULT: k_d = k_q;
      default:  k_d = 2'd0;
    endcase
  end

  // Result outputs, sticky overrun and handshake counter
  always_comb begin
    win_valid_d    = win_valid_q;
    win_idx_d      = win_idx_q;
    win_onehot_d   = win_onehot_q;
    win_value_d    = win_value_q;
    no_winner_d    = no_winner_q;
    multi_winner_d = multi_winner_q;
    overrun_d      = overrun_q;
    run_count_d    = run_count_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) overrun_d = 1'b0;
        else         overrun_d = overrun_q;
      end
      S_SCAN: begin
        if (start_s) overrun_d = 1'b1;
        else         overrun_d = overrun_q;
        if (k_q == 2'd3) begin
          win_valid_d    = 1'b1;
          win_idx_d      = best_idx_nx_s;
          win_value_d    = best_val_nx_s;
          no_winner_d    = (pos_cnt_nx_s == 3'd0);
          multi_winner_d = (pos_cnt_nx_s > 3'd1);
          if (pos_cnt_nx_s == 3'd0) win_onehot_d = 4'b0000;
          else                      win_onehot_d = idx_decode(best_idx_nx_s);
        end else begin
          win_valid_d = 1'b0;
        end
      end
      S_RESULT: begin
        if (start_s) overrun_d = 1'b1;
        else         overrun_d = overrun_q;
        if (handshake_s) begin
          win_valid_d = 1'b0;
          run_count_d = run_count_q + 16'd1;
        end else begin
          win_valid_d = win_valid_q;
        end
      end
      default: win_valid_d = 1'b0;
    endcase
  end

  // State register and all flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      done_d_q       <= 1'b0;
      for (int i = 0; i < 4; i++) v_q[i] <= {W{1'b0}};
      best_idx_q     <= 2'd0;
      best_val_q     <= {W{1'b0}};
      pos_cnt_q      <= 3'd0;
      k_q            <= 2'd0;
      win_valid_q    <= 1'b0;
      win_idx_q      <= 2'd0;
      win_onehot_q   <= 4'b0000;
      win_value_q    <= {W{1'b0}};
      no_winner_q    <= 1'b0;
      multi_winner_q <= 1'b0;
      overrun_q      <= 1'b0;
      run_count_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      done_d_q       <= done;
      v_q            <= v_d;
      best_idx_q     <= best_idx_d;
      best_val_q     <= best_val_d;
      pos_cnt_q      <= pos_cnt_d;
      k_q            <= k_d;
      win_valid_q    <= win_valid_d;
      win_idx_q      <= win_idx_d;
      win_onehot_q   <= win_onehot_d;
      win_value_q    <= win_value_d;
      no_winner_q    <= no_winner_d;
      multi_winner_q <= multi_winner_d;
      overrun_q      <= overrun_d;
      run_count_q    <= run_count_d;
    end
  end

  assign win_valid    = win_valid_q;
  assign win_idx      = win_idx_q;
  assign win_onehot   = win_onehot_q;
  assign win_value    = win_value_q;
  assign no_winner    = no_winner_q;
  assign multi_winner = multi_winner_q;
  assign overrun      = overrun_q;
`ifdef MAXNET_STATS_EN
  assign run_count    = run_count_q;
`else
  logic unused_run_count_s;
  assign unused_run_count_s = ^run_count_q;
`endif

endmodule

// File: tb/tb_maxnet_winner_select.sv
// Bench for maxnet_winner_select: transaction-level reference model compared
// every cycle, plus directed cases with hand-computed results.
module tb_maxnet_winner_select;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done = 1'b0;
  logic [4:0]  pu1 = 5'd0, pu2 = 5'd0, pu3 = 5'd0, pu4 = 5'd0;
  logic        win_ready = 1'b0;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [3:0]  win_onehot;
  logic [4:0]  win_value;
  logic        no_winner, multi_winner, overrun;
`ifdef MAXNET_STATS_EN
  logic [15:0] run_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  maxnet_winner_select #(.W(5), .FRAC(3)) dut (
    .clk(clk), .rst(rst), .done(done),
    .pu_out1(pu1), .pu_out2(pu2), .pu_out3(pu3), .pu_out4(pu4),
    .win_ready(win_ready), .win_valid(win_valid), .win_idx(win_idx),
    .win_onehot(win_onehot), .win_value(win_value), .no_winner(no_winner),
    .multi_winner(multi_winner), .overrun(overrun)
`ifdef MAXNET_STATS_EN
    , .run_count(run_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: winner is the first maximum; count activations strictly above zero
  function automatic int best_of(input logic signed [4:0] a [4]);
    int bi = 0;
    for (int i = 1; i < 4; i++) if (a[i] > a[bi]) bi = i;
    return bi;
  endfunction

  function automatic int npos_of(input logic signed [4:0] a [4]);
    int n = 0;
    for (int i = 0; i < 4; i++) if (a[i] > 5'sd0) n++;
    return n;
  endfunction

  logic signed [4:0] m_cap [4];
  int          m_phase = 0;   // 0 idle, 1..4 cycles since capture, 5 result held
  logic        m_prev = 1'b0;
  logic        e_valid = 1'b0, e_nw = 1'b0, e_mw = 1'b0, e_ovr = 1'b0;
  logic [1:0]  e_idx = 2'd0;
  logic [3:0]  e_oh = 4'd0;
  logic [4:0]  e_val = 5'd0;
  logic [15:0] e_cnt = 16'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_prev <= 1'b0; e_valid <= 1'b0; e_nw <= 1'b0; e_mw <= 1'b0;
      e_ovr <= 1'b0; e_idx <= 2'd0; e_oh <= 4'd0; e_val <= 5'd0; e_cnt <= 16'd0;
      for (int i = 0; i < 4; i++) m_cap[i] <= 5'sd0;
    end else begin
      m_prev <= done;
      if (m_phase == 0) begin
        if (done && !m_prev) begin
          m_cap[0] <= pu1; m_cap[1] <= pu2; m_cap[2] <= pu3; m_cap[3] <= pu4;
          m_phase <= 1;
          e_ovr <= 1'b0;
        end
      end else if (m_phase < 5) begin
        if (done && !m_prev) e_ovr <= 1'b1;
        if (m_phase == 4) begin
          e_valid <= 1'b1;
          e_idx   <= 2'(best_of(m_cap));
          e_val   <= m_cap[best_of(m_cap)];
          e_nw    <= (npos_of(m_cap) == 0);
          e_mw    <= (npos_of(m_cap) > 1);
          e_oh    <= (npos_of(m_cap) == 0) ? 4'd0 : (4'd1 << best_of(m_cap));
          m_phase <= 5;
        end else begin
          m_phase <= m_phase + 1;
        end
      end else begin
        if (done && !m_prev) e_ovr <= 1'b1;
        if (win_ready) begin
          e_valid <= 1'b0;
          m_phase <= 0;
          e_cnt   <= e_cnt + 16'd1;
        end
      end
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    chk("valid", win_valid, e_valid);
    chk("idx", win_idx, e_idx);
    chk("onehot", win_onehot, e_oh);
    chk("value", win_value, e_val);
    chk("no_winner", no_winner, e_nw);
    chk("multi_winner", multi_winner, e_mw);
    chk("overrun", overrun, e_ovr);
`ifdef MAXNET_STATS_EN
    chk("run_count", run_count, e_cnt);
`endif
  end

  // Pulse done with the given vector, wait for the result and check literals
  task automatic run_case(input string tag, input logic [4:0] a, b, c, d, input logic rdy,
                          input logic [1:0] x_idx, input logic [3:0] x_oh,
                          input logic [4:0] x_val, input logic x_nw, input logic x_mw);
    int cnt;
    @(negedge clk);
    pu1 = a; pu2 = b; pu3 = c; pu4 = d; done = 1'b1; win_ready = rdy;
    @(negedge clk);
    cnt = 1;
    done = 1'b0;
    chk({tag, "_ovr_clear"}, overrun, 0);
    pu1 = 5'(~a); pu2 = 5'(~b); pu3 = 5'(a ^ 5'b10101); pu4 = 5'b01111;
    while (!win_valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, cnt - 1, 4);
    chk({tag, "_idx"}, win_idx, x_idx);
    chk({tag, "_onehot"}, win_onehot, x_oh);
    chk({tag, "_value"}, win_value, x_val);
    chk({tag, "_no_winner"}, no_winner, x_nw);
    chk({tag, "_multi"}, multi_winner, x_mw);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", win_valid, 0);
    chk("reset_idx", win_idx, 0);
    rst = 1'b1;
    win_ready = 1'b1;

    run_case("single", 5'b00101, 5'd0, 5'd0, 5'd0, 1'b1, 2'd0, 4'b0001, 5'b00101, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_drop", win_valid, 0);
    run_case("nowin", 5'd0, 5'b11110, 5'd0, 5'b11000, 1'b1, 2'd0, 4'b0000, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("nowin_drop", win_valid, 0);
    run_case("tie", 5'b00010, 5'b00110, 5'b00110, 5'd0, 1'b1, 2'd1, 4'b0010, 5'b00110, 1'b0, 1'b1);
    @(negedge clk);
    chk("tie_drop", win_valid, 0);
`ifdef MAXNET_STATS_EN
    chk("stats_three", run_count, 3);
`endif
    run_case("allneg", 5'b11000, 5'b11000, 5'b11000, 5'b11000, 1'b1, 2'd0, 4'b0000, 5'b11000, 1'b1, 1'b0);
    @(negedge clk);

    // Backpressure with a dropped done edge
    run_case("bp", 5'b11111, 5'b00011, 5'b00111, 5'b00111, 1'b0, 2'd2, 4'b0100, 5'b00111, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) done = 1'b1;
      if (i == 5) done = 1'b0;
      chk("bp_valid", win_valid, 1);
      chk("bp_idx", win_idx, 2);
      chk("bp_value", win_value, 5'b00111);
    end
    chk("bp_overrun", overrun, 1);
    win_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", win_valid, 0);
    chk("bp_overrun_held", overrun, 1);
    run_case("last", 5'b00001, 5'b00010, 5'b00011, 5'b00100, 1'b1, 2'd3, 4'b1000, 5'b00100, 1'b0, 1'b1);
    @(negedge clk);

    // Reset mid-scan, then release with done already high
    pu1 = 5'b00110; pu2 = 5'd0; pu3 = 5'd0; pu4 = 5'd0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", win_valid, 0);
    chk("rst_idx", win_idx, 0);
    chk("rst_onehot", win_onehot, 0);
    chk("rst_value", win_value, 0);
    chk("rst_multi", multi_winner, 0);
    run_case("rst_release", 5'b00011, 5'd0, 5'd0, 5'b00001, 1'b1, 2'd0, 4'b0001, 5'b00011, 1'b0, 1'b1);
    @(negedge clk);
    chk("final_drop", win_valid, 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // The reset-release case raises rst in the same step as done
  always @(negedge clk) begin
    if (!rst && done) rst <= 1'b1;
  end

endmodule

// File: doc/maxnet_winner_select.md
# maxnet_winner_select

Downstream result stage for the four-unit cellular MaxNet. It watches the MaxNet `done` flag, captures the four processing-unit outputs on its rising edge, and scans them sequentially to pick the winner. The result is held behind a valid/ready handshake: winner index, one-hot vector, value, and no-winner / tie status flags. It sits between `maxnet_cellular` and whatever consumes the classification.

## Interface
Parameters:
- `W`, 5: data width of each PU output; signed two's complement.
- `FRAC`, 3: fractional bits, so 5'b01000 = 1.0. Informational only; comparisons are pure signed compares.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `done`  in  1  MaxNet convergence flag; may stay high for many cycles.
- `pu_out1`..`pu_out4`  in  W each  MaxNet unit activations (signed).
- `win_ready`  in  1  consumer accepts the result.
- `win_valid`  out  1  result available and stable.
- `win_idx`  out  2  winning unit (0 = `pu_out1` ... 3 = `pu_out4`).
- `win_onehot`  out  4  one-hot winner; bit i = unit i+1; all zero when `no_winner`.
- `win_value`  out  W  activation of the winner.
- `no_winner`  out  1  no activation is strictly positive.
- `multi_winner`  out  1  two or more activations are strictly positive.
- `overrun`  out  1  a `done` rising edge arrived while busy.
- `run_count`  out  16  only present with `MAXNET_STATS_EN`.

## Operation
- **Edge detect:**
  - `done_d` is a register of `done`, reset to 0.
  - Start condition: `done & ~done_d`.
  - Consequence: if `done` is high when reset is released, that counts as a rising edge.
- **FSM states:** IDLE, SCAN, RESULT.
- **IDLE:**
  - On the start condition, copy `pu_out1..4` into internal regs `v[0..3]`.
  - Set `best_idx`=0, `best_val`=`v[0]` (taken from `pu_out1` directly), `pos_cnt`=0, `k`=0, `overrun`=0.
  - Go to SCAN.
- **SCAN (k = 0..3, one unit per cycle):**
  - If `v[k]` is strictly positive (sign bit 0 and nonzero), increment `pos_cnt` (3 bits, saturating at 4).
  - If k>0 and `v[k]` > `best_val` (signed), update `best_idx`/`best_val`. On equal values the lower index wins.
  - After k=3, go to RESULT and drive the outputs.
- **RESULT outputs:**
  - `win_idx`=`best_idx`, `win_value`=`best_val`.
  - `no_winner`=(`pos_cnt`==0), `multi_winner`=(`pos_cnt`>1).
  - `win_onehot` = decode(`best_idx`) unless `no_winner`, in which case it is 4'b0000.
  - `win_valid`=1.
- **RESULT exit:**
  - Outputs stay frozen until an edge with `win_valid & win_ready`.
  - On that edge: `win_valid`←0, FSM→IDLE.
  - All other result outputs keep their last values until the next RESULT.
- **Busy edge:** a `done` rising edge in SCAN or RESULT is dropped and sets sticky `overrun`. It is not queued.
- **Reset (any state, asynchronous):**
  - FSM→IDLE.
  - Every output → 0, including `win_idx`=0 and `run_count`=0.
  - `v`, `best_*`, `pos_cnt`, `k`, `done_d` → 0.

## Timing
- Capture edge = E, the edge at which the start condition is sampled in IDLE.
- SCAN occupies edges E+1..E+4. `win_valid` rises after edge E+4, giving a 4-cycle latency.
- Ready already high in RESULT: `win_valid` is high for exactly one cycle and drops after edge E+5.
- Earliest next capture: edge E+6. A back-to-back cycle takes 6 cycles.
- `win_ready` is ignored outside RESULT.
- `pu_out*` changes after E do not affect the result.

## Configuration
- **Macro `MAXNET_STATS_EN` defined:**
  - Port `run_count` exists.
  - It increments by 1 on every accepted handshake (`win_valid & win_ready`) and wraps 16'hFFFF→0.
  - Reset value is 0.
- **Macro undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Single winner:** `pu_out`={5'b00101,0,0,0}, pulse `done`, `win_ready`=1.
  - `win_valid` high 4 cycles after capture.
  - `win_idx`=0, `win_onehot`=4'b0001, `win_value`=5'b00101.
  - `no_winner`=0, `multi_winner`=0.
- **No winner:** `pu_out`={0,5'b11110,0,5'b11000}.
  - `no_winner`=1, `win_onehot`=0, `win_idx`=0, `win_value`=0.
- **Tie:** `pu_out`={5'b00010,5'b00110,5'b00110,0}.
  - `win_idx`=1, `multi_winner`=1, `win_onehot`=4'b0010.
- **Backpressure:** hold `win_ready`=0 for 10 cycles.
  - Outputs stable throughout; `win_valid` stays 1.
  - Pulse a second `done` during this window: `overrun`=1 and no new capture.
  - Raise `win_ready`: `win_valid` falls after one edge.
  - Next `done` edge: `overrun` clears.
- **Reset:**
  - Drop `rst` mid-SCAN: all outputs 0 immediately, FSM in IDLE.
  - Release `rst` with `done` held high: capture occurs at the first edge.
- **Stats (`MAXNET_STATS_EN`):** three handshakes → `run_count`=3. Preload path via reset: reset gives 0, and the counter wraps after 65536 accepts.
